// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline package: skid-stage state encoding and the per-stage payload
// bundles that stages pack into a stage register's data word.
package pipe_skid_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int unsigned XLEN = 32;

    // ID/EXE bundle; the ID stage instantiates its register with WIDTH = $bits(id_exe_t).
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] u_imm;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] alu_b;
        logic [15:0]     ctrl;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            pred_taken;
        logic            btb_hit;
    } id_exe_t;

    localparam int unsigned ID_EXE_W = $bits(id_exe_t);

endpackage

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready on both sides, a one-entry skid
// buffer so in_ready is a pure state decode, flush-to-bubble and a stall counter.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    skid_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic [WIDTH-1:0] skid_q,  skid_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic in_fire;
    logic out_fire;

    // Handshake outputs decode only the state register, so neither side sees
    // a combinational path from the other.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign stall_cnt = cnt_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;

        // Stall cycles are counted even in a flush cycle; saturate instead of wrapping.
        if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (out_fire) begin
                        main_d  = '0;
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // Skid moves up behind main, keeping strict FIFO order.
                    if (out_fire) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = BUSY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // NOTE: main and skid are ordinary registers, not a memory array, so they are reset to keep out_data zero on a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: table-driven cycle vectors, a data
// scoreboard for ordering, and hand sequences for async reset and saturation.
module tb_pipe_skid_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] stall_cnt;

    // Small instance for counter saturation.
    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_in_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_out_data;
    logic [1:0]  s_stall_cnt;
    logic        s_flush;

    int n_vec  = 0;
    int n_fail = 0;

    logic [31:0] sb[$];

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [15:0] e_st;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    pipe_skid_stage #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .flush     (s_flush),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .stall_cnt (s_stall_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic fl, input logic iv, input logic [31:0] id, input logic ordy,
                           input logic e_ir, input logic e_ov, input logic [31:0] e_od,
                           input logic [15:0] e_st);
        vec_t v;
        v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_st = e_st;
        vecs.push_back(v);
    endtask

    // Called at a falling edge: drive inputs, update the scoreboard from this
    // cycle's handshake, then advance to the next falling edge.
    task automatic cycle(input logic fl, input logic iv, input logic [31:0] id, input logic ordy);
        logic [31:0] exp_d;
        flush     = fl;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_out", out_data, 32'hDEAD_BEEF);
            end else begin
                exp_d = sb.pop_front();
                check("sb_out_data", out_data, exp_d);
            end
        end
        if (in_valid && in_ready && !flush) sb.push_back(in_data);
        if (flush) sb.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;

        //      fl iv  data   ordy  ir ov  od     stall
        // Streaming
        add_vec(0, 1, 32'h1,  1,    1, 1, 32'h1,  0);
        add_vec(0, 1, 32'h2,  1,    1, 1, 32'h2,  0);
        add_vec(0, 1, 32'h3,  1,    1, 1, 32'h3,  0);
        add_vec(0, 0, 32'h0,  1,    1, 0, 32'h0,  0);
        // Backpressure: A lands, B goes to skid, C refused; stalls counted once A is visible
        add_vec(0, 1, 32'hA,  0,    1, 1, 32'hA,  0);
        add_vec(0, 1, 32'hB,  0,    0, 1, 32'hA,  1);
        add_vec(0, 1, 32'hC,  0,    0, 1, 32'hA,  2);
        add_vec(0, 1, 32'hC,  0,    0, 1, 32'hA,  3);
        add_vec(0, 1, 32'hC,  1,    1, 1, 32'hB,  3);
        add_vec(0, 1, 32'hC,  1,    1, 1, 32'hC,  3);
        add_vec(0, 0, 32'h0,  1,    1, 0, 32'h0,  3);
        // Single-cycle out_ready drop
        add_vec(0, 1, 32'h10, 1,    1, 1, 32'h10, 3);
        add_vec(0, 1, 32'h11, 0,    0, 1, 32'h10, 4);
        add_vec(0, 1, 32'h12, 1,    1, 1, 32'h11, 4);
        add_vec(0, 1, 32'h12, 1,    1, 1, 32'h12, 4);
        add_vec(0, 0, 32'h0,  1,    1, 0, 32'h0,  4);
        // Flush while FULL with 0xD offered; flush cycle still counts a stall
        add_vec(0, 1, 32'h20, 0,    1, 1, 32'h20, 4);
        add_vec(0, 1, 32'h21, 0,    0, 1, 32'h20, 5);
        add_vec(1, 1, 32'hD,  0,    1, 0, 32'h0,  6);
        add_vec(0, 0, 32'h0,  1,    1, 0, 32'h0,  6);
        // Flush in BUSY with simultaneous delivery and a discarded offer
        add_vec(0, 1, 32'h30, 1,    1, 1, 32'h30, 6);
        add_vec(1, 1, 32'h31, 1,    1, 0, 32'h0,  6);
        add_vec(0, 0, 32'h0,  1,    1, 0, 32'h0,  6);

        #12;
        check("reset in_ready",  32'(in_ready),  32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data",  out_data,       32'd0);
        check("reset stall_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            cycle(vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
            check($sformatf("v%0d in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("v%0d out_data", i),  out_data,       vecs[i].e_od);
            check($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].e_st));
        end
        check("sb drained", 32'(sb.size()), 32'd0);

        // Reset mid-stream while FULL: outputs must clear before any clock edge.
        cycle(0, 1, 32'h40, 0);
        cycle(0, 1, 32'h41, 0);
        check("pre-reset full", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async rst in_ready",  32'(in_ready),  32'd1);
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst out_data",  out_data,       32'd0);
        check("async rst stall_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        cycle(0, 0, 32'h0, 1);
        check("post-reset out_valid", 32'(out_valid), 32'd0);

        // Saturation on the CNT_W=2 instance.
        s_in_valid = 1'b1; s_in_data = 8'h5A; s_out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        s_in_valid = 1'b0;
        check("sat out_data", 32'(s_out_data), 32'h5A);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("sat stall k=%0d", k), 32'(s_stall_cnt), 32'((k < 3) ? k : 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
